// File: rtl/j_i2s_pkg.sv
// Shared definitions for the JERRY I2S receive path.
package j_i2s_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StWait  = 2'd2
    } state_e;

    localparam int unsigned I2S_WIDTH = 16;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/j_syncff.sv
// Multi-stage flop synchroniser for one asynchronous input, with synchronous active-low clear.
module j_syncff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/j_i2s_rx_shift.sv
// I2S receive deserialiser: synchronises sck/ws/sd into sys_clk and emits MSB-first words
// with one-cycle left/right load strobes or a frame-error strobe for short slots.
module j_i2s_rx_shift
    import j_i2s_pkg::*;
#(
    parameter int unsigned WIDTH       = I2S_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             enable,
    input  logic             sck,
    input  logic             ws,
    input  logic             sd,
    output logic [WIDTH-1:0] data,
    output logic             ld_left,
    output logic             ld_right,
    output logic             frame_err,
    output logic             chan
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic sck_s, ws_s, sd_s;

    j_syncff #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk  (sys_clk),
        .rstn (resetl),
        .d    (sck),
        .q    (sck_s)
    );

    j_syncff #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .clk  (sys_clk),
        .rstn (resetl),
        .d    (ws),
        .q    (ws_s)
    );

    j_syncff #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk  (sys_clk),
        .rstn (resetl),
        .d    (sd),
        .q    (sd_s)
    );

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-2:0]  shift_q;
    logic              ws_prev_q;
    logic              sck_prev_q;

    logic              bit_ev;
    logic              ws_chg;
    logic [WIDTH-1:0]  word;

    assign bit_ev = sck_s & ~sck_prev_q;
    assign ws_chg = ws_s ^ ws_prev_q;
    assign word   = {shift_q, sd_s};

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            ws_prev_q  <= 1'b0;
            sck_prev_q <= 1'b0;
            data       <= '0;
            ld_left    <= 1'b0;
            ld_right   <= 1'b0;
            frame_err  <= 1'b0;
            chan       <= LEFT;
        end else begin
            sck_prev_q <= sck_s;
            ld_left    <= 1'b0;
            ld_right   <= 1'b0;
            frame_err  <= 1'b0;
            // ws history tracks every bit, even while disabled, so re-enable sees true edges
            if (bit_ev) begin
                ws_prev_q <= ws_s;
            end
            if (!enable) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else if (bit_ev) begin
                unique case (state_q)
                    StIdle: begin
                        if (ws_chg) begin
                            state_q <= StShift;
                            chan    <= ws_s;
                            cnt_q   <= '0;
                        end
                    end
                    StShift: begin
                        if (cnt_q == CntLast) begin
                            data     <= word;
                            ld_left  <= (chan == LEFT);
                            ld_right <= (chan == RIGHT);
                            if (ws_chg) begin
                                chan  <= ws_s;
                                cnt_q <= '0;
                            end else begin
                                state_q <= StWait;
                            end
                        end else if (ws_chg) begin
                            frame_err <= 1'b1;
                            chan      <= ws_s;
                            cnt_q     <= '0;
                        end else begin
                            shift_q <= word[WIDTH-2:0];
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                    StWait: begin
                        if (ws_chg) begin
                            state_q <= StShift;
                            chan    <= ws_s;
                            cnt_q   <= '0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_j_i2s_rx_shift.sv
// Table-driven bench for j_i2s_rx_shift: I2S slots are serialised bit by bit and every strobe
// is logged with its data and latency, then compared against per-slot expectations.
module tb_j_i2s_rx_shift;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SYNC  = 2;
    localparam int LAT = SYNC + 1;  // posedges from the rise-driving negedge to the strobe negedge
    localparam int KL = 0;
    localparam int KR = 1;
    localparam int KE = 2;
    localparam int NSLOT = 8;

    logic             sys_clk = 1'b0;
    logic             resetl, enable, sck, ws, sd;
    logic [WIDTH-1:0] data;
    logic             ld_left, ld_right, frame_err, chan;

    j_i2s_rx_shift #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .enable    (enable),
        .sck       (sck),
        .ws        (ws),
        .sd        (sd),
        .data      (data),
        .ld_left   (ld_left),
        .ld_right  (ld_right),
        .frame_err (frame_err),
        .chan      (chan)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int               kind;
        logic [WIDTH-1:0] data;
        int               lat;
    } ev_t;

    typedef struct {
        logic             ws;
        int               nbits;
        logic [31:0]      payload;
        int               kind;
        logic [WIDTH-1:0] exp_data;
    } slot_t;

    ev_t   ev_q[$];
    ev_t   exp_q[$];
    slot_t tbl[NSLOT];

    int cyc = 0;
    int last_rise = 0;
    int excl_bad = 0;
    int n_pass = 0;
    int n_total = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if ($countones({ld_left, ld_right, frame_err}) > 1) excl_bad++;
        if (ld_left === 1'b1) ev_q.push_back('{KL, data, cyc - last_rise});
        if (ld_right === 1'b1) ev_q.push_back('{KR, data, cyc - last_rise});
        if (frame_err === 1'b1) ev_q.push_back('{KE, data, cyc - last_rise});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic exp_ev(input int kind, input logic [WIDTH-1:0] d);
        exp_q.push_back('{kind, d, LAT});
    endtask

    task automatic check_events(input string tag);
        check({tag, " event count"}, ev_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < ev_q.size(); j++) begin
            check($sformatf("%s ev%0d kind", tag, j), ev_q[j].kind, exp_q[j].kind);
            check($sformatf("%s ev%0d data", tag, j), 32'(ev_q[j].data), 32'(exp_q[j].data));
            check($sformatf("%s ev%0d latency", tag, j), ev_q[j].lat, exp_q[j].lat);
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    // One sck period: low phase carries the new sd/ws, then h cycles high.
    task automatic send_bit(input logic b, input logic w, input int h);
        @(negedge sys_clk);
        sck = 1'b0;
        sd  = b;
        ws  = w;
        repeat (h) @(negedge sys_clk);
        sck = 1'b1;
        last_rise = cyc;
        repeat (h - 1) @(negedge sys_clk);
    endtask

    task automatic send_word(input logic [31:0] p, input int n, input logic w, input logic wn,
                             input int h);
        for (int b = n - 1; b >= 0; b--) send_bit(p[b], (b == 0) ? wn : w, h);
    endtask

    // Leaves the receiver in SHIFT on the left channel with ws_prev = 0.
    task automatic preamble(input int h);
        enable = 1'b0;
        send_bit(1'b0, 1'b1, h);
        send_bit(1'b0, 1'b1, h);
        enable = 1'b1;
        send_bit(1'b1, 1'b0, h);
    endtask

    task automatic run_table(input int h);
        logic wn;
        for (int i = 0; i < NSLOT; i++) begin
            wn = ~tbl[i].ws;
            if (i < NSLOT - 1) wn = tbl[i + 1].ws;
            send_word(tbl[i].payload, tbl[i].nbits, tbl[i].ws, wn, h);
            exp_ev(tbl[i].kind, tbl[i].exp_data);
        end
        repeat (4 * h) @(negedge sys_clk);
    endtask

    initial begin
        tbl[0] = '{1'b0, 16, 32'h0000_A5C3, KL, 16'hA5C3};
        tbl[1] = '{1'b1, 16, 32'h0000_1234, KR, 16'h1234};
        tbl[2] = '{1'b0, 24, 32'h00AB_CDEF, KL, 16'hABCD};
        tbl[3] = '{1'b1, 16, 32'h0000_5A0F, KR, 16'h5A0F};
        tbl[4] = '{1'b0, 10, 32'h0000_02AB, KE, 16'h5A0F};
        tbl[5] = '{1'b1, 16, 32'h0000_BEEF, KR, 16'hBEEF};
        tbl[6] = '{1'b0, 16, 32'h0000_8001, KL, 16'h8001};
        tbl[7] = '{1'b1, 16, 32'h0000_FFFF, KR, 16'hFFFF};

        resetl = 1'b0;
        enable = 1'b1;
        sck = 1'b0;
        ws  = 1'b0;
        sd  = 1'b0;
        repeat (3) @(negedge sys_clk);
        resetl = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("reset data", 32'(data), 32'h0);
        check("reset strobes", {29'h0, ld_left, ld_right, frame_err}, 32'h0);
        check("reset chan", {31'h0, chan}, 32'h0);
        check_events("reset");

        preamble(4);
        check("chan after preamble", {31'h0, chan}, 32'h0);
        run_table(4);
        check_events("sck8");

        // Partial word then reset: must vanish without a strobe, data cleared.
        send_word(32'h0000_00C5, 8, 1'b0, 1'b0, 4);
        @(negedge sys_clk);
        resetl = 1'b0;
        repeat (2) @(negedge sys_clk);
        resetl = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("midword reset data", 32'(data), 32'h0);
        check_events("midword reset");

        // Minimum legal sck phases.
        preamble(SYNC + 1);
        run_table(SYNC + 1);
        check_events("sck_min");

        // Enable dropped after bit 7 of a right slot.
        preamble(4);
        send_word(32'h0000_1111, 16, 1'b0, 1'b1, 4);
        send_word(32'h0000_00CC, 7, 1'b1, 1'b1, 4);
        check("chan mid right slot", {31'h0, chan}, 32'h1);
        enable = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("data held while disabled", 32'(data), 32'h1111);
        enable = 1'b1;
        send_word(32'h0000_01CC, 9, 1'b1, 1'b0, 4);
        send_word(32'h0000_2222, 16, 1'b0, 1'b1, 4);
        repeat (16) @(negedge sys_clk);
        exp_ev(KL, 16'h1111);
        exp_ev(KL, 16'h2222);
        check_events("enable drop");

        check("strobe exclusivity", excl_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/j_i2s_rx_shift.md
Name: j_i2s_rx_shift

Overview:
- Serial-audio front end for JERRY's I2S receive path.
- Synchronises external sck/ws/sd into sys_clk and deserialises MSB-first words.
- Emits one-cycle load strobes plus a parallel word, which drive the en/d inputs of the downstream left/right enable-latch register banks.
- Directly upstream of those latch banks; no backpressure. The banks capture when strobed.

Parameters:
WIDTH, 16, bits captured per channel slot (2..32)
SYNC_STAGES, 2, flip-flop stages on each async input (2..3)

Ports:
sys_clk  in  1  system clock; sole clock domain
resetl  in  1  synchronous active-low reset, sampled on sys_clk rising edge
enable  in  1  receiver enable; low forces IDLE
sck  in  1  external serial bit clock, async to sys_clk
ws  in  1  external word select, async (0 = left, 1 = right)
sd  in  1  external serial data, async
data  out  WIDTH  last completed word, registered
ld_left  out  1  one-cycle strobe: data holds a left word
ld_right  out  1  one-cycle strobe: data holds a right word
frame_err  out  1  one-cycle strobe: slot ended short, word discarded
chan  out  1  channel of the word currently being shifted, registered

Behaviour:
- Reset (resetl=0 at a sys_clk edge): state=IDLE; data=0, ld_left=0, ld_right=0, frame_err=0, chan=0; shift reg, bit count and ws_prev cleared; synchroniser stages cleared.
- sck, ws and sd each pass through SYNC_STAGES flops. Bit event = rising edge of synchronised sck, i.e. sck_s=1 while registered previous sck_s=0.
- All state changes occur only on bit events. ws_s and sd_s are sampled at the bit event.
- ws_chg = sampled ws differs from ws_prev. ws_prev is updated on every bit event, in every state.
- Input constraint: sck high and low phases are each at least SYNC_STAGES+1 sys_clk periods. Faster sck is unsupported.
- IDLE: on a bit event with ws_chg, go to SHIFT with chan<=ws and cnt<=0. The bit on that event is discarded (it is the previous slot's LSB).
- SHIFT, bit event without ws_chg:
  - shift sd in at the LSB and increment cnt.
  - When cnt==WIDTH-1: load data with the completed word, pulse ld_left (chan=0) or ld_right (chan=1), then go to WAIT.
- SHIFT, bit event with ws_chg:
  - If cnt==WIDTH-1: this bit is the LSB. Complete the word and strobe as above, then stay in SHIFT with chan<=ws and cnt<=0. This is the exact-length slot; no bit is lost.
  - If cnt<WIDTH-1: pulse frame_err, leave data unchanged, no ld strobe, restart SHIFT with chan<=ws and cnt<=0. The bit is discarded.
- WAIT: bits beyond WIDTH are ignored (truncation of longer slots). On ws_chg, go to SHIFT with chan<=ws and cnt<=0; the bit is discarded.
- enable=0 at any sys_clk edge: go to IDLE and abort any partial word. No strobes are issued. data is held; ws_prev keeps tracking.
- Strobes are registered and high exactly one sys_clk. data updates on the same edge the strobe rises and holds until the next strobe.
- Latency: the strobe and data appear SYNC_STAGES sys_clk edges after the first edge that samples the final sck rising high.
- ld_left, ld_right and frame_err are mutually exclusive.
- Reset mid-word discards the word, with no strobe.

Decomposition:
- Shared package j_i2s_pkg holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, WAIT=2'd2);
  - the I2S_WIDTH default of 16;
  - the channel constants LEFT=0 and RIGHT=1.
- One sub-module: j_syncff, a SYNC_STAGES-deep synchroniser with synchronous active-low clear, instantiated three times (sck, ws, sd).

Test Plan:
- Reset: hold resetl=0 for 3 cycles, then release -> all outputs 0, state IDLE, no strobe during or after reset.
- Exact 16-bit slots, sck=8 sys_clk period, left=16'hA5C3 then right=16'h1234 -> ld_left with data=16'hA5C3, then ld_right with data=16'h1234. Each strobe is 1 cycle, SYNC_STAGES edges after the LSB sck rise. Continuous frames produce no gaps.
- 24-bit slots, left=24'hABCDEF -> data=16'hABCD on ld_left; the extra bits are ignored; the next channel is captured correctly.
- Short slot: ws toggles after 10 bits -> frame_err pulse, no ld strobe, data keeps its prior value. The following full 16-bit word is captured.
- Drop enable mid-word at bit 7, re-raise 20 cycles later -> no strobe for the aborted word. Capture resumes at the next ws change.
- Glitch check: sck phases at exactly SYNC_STAGES+1 sys_clk -> exactly one bit event per sck rise and correct data; assert strobe mutual exclusion throughout.
